// File: rtl/keypad_entry_display_pkg.sv
// Shared constants for the keypad entry/display block: key codes, widths,
// and the active-low hex segment table.
package keypad_entry_display_pkg;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned KEY_W       = 4;
  localparam int unsigned VALUE_W     = 16;
  localparam int unsigned COUNT_W     = 3;
  localparam int unsigned IDX_W       = 2;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned DIV_W       = 16;
  localparam int unsigned SEG_ENTRIES = 14;

  localparam logic [KEY_W-1:0] KEY_BKSP  = 4'hE;
  localparam logic [KEY_W-1:0] KEY_CLR   = 4'hF;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Entry i is the active-low pattern (bit0=a .. bit6=g) for hex digit i.
  localparam logic [SEG_ENTRIES-1:0][SEG_W-1:0] SEG_TABLE = {
    7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00, 7'h78,
    7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic [1:0] {
    KIND_DIGIT,
    KIND_BKSP,
    KIND_CLR
  } key_kind_e;

  function automatic key_kind_e classify_key(input logic [KEY_W-1:0] code);
    if (code == KEY_CLR)       return KIND_CLR;
    else if (code == KEY_BKSP) return KIND_BKSP;
    else                       return KIND_DIGIT;
  endfunction

endpackage

// File: rtl/keypad_entry_display_hex_to_seg7.sv
// Combinational hex-to-7-segment decoder, active-low; codes beyond the table
// decode to blank.
module hex_to_seg7
  import keypad_entry_display_pkg::*;
(
  input  logic [KEY_W-1:0] hex_i,
  output logic [SEG_W-1:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (hex_i < KEY_W'(SEG_ENTRIES)) begin
      seg_o = SEG_TABLE[hex_i];
    end
  end

endmodule

// File: rtl/keypad_entry_display.sv
// 4-digit hex entry buffer fed by keypad strobes, time-multiplexed onto a
// shared active-low 7-segment bus with active-low digit enables.
module keypad_entry_display
  import keypad_entry_display_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 4
) (
  input  logic               clk,
  input  logic               res,
  input  logic               key_valid,
  input  logic [KEY_W-1:0]   key_code,
  output logic [VALUE_W-1:0] value,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               err,
  output logic [SEG_W-1:0]   seg,
  output logic [DIGITS-1:0]  dig_sel
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [VALUE_W-1:0] value_q, value_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               full_q, full_d;
  logic               err_q, err_d;
  logic [SEG_W-1:0]   seg_q, seg_d;
  logic [DIGITS-1:0]  dig_sel_q, dig_sel_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [KEY_W-1:0]   cur_digit;
  logic [SEG_W-1:0]   cur_seg;

  assign cur_digit = KEY_W'(value_q >> {idx_q, 2'b00});

  hex_to_seg7 u_dec (
    .hex_i (cur_digit),
    .seg_o (cur_seg)
  );

  // Entry buffer: shift in digits, backspace shifts out, clear empties.
  always_comb begin
    value_d = value_q;
    count_d = count_q;
    err_d   = 1'b0;
    if (key_valid) begin
      case (classify_key(key_code))
        KIND_DIGIT: begin
          if (count_q < COUNT_W'(DIGITS)) begin
            value_d = {value_q[VALUE_W-KEY_W-1:0], key_code};
            count_d = count_q + COUNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        KIND_BKSP: begin
          if (count_q != '0) begin
            value_d = {KEY_W'(0), value_q[VALUE_W-1:KEY_W]};
            count_d = count_q - COUNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
        end
        KIND_CLR: begin
          value_d = '0;
          count_d = '0;
        end
        default: ;
      endcase
    end
    full_d = (count_d == COUNT_W'(DIGITS));
  end

  // Free-running scan; unentered digits stay enabled but blank.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_LAST) begin
      div_d = '0;
      idx_d = idx_q + IDX_W'(1);
    end
    dig_sel_d = ~(DIGITS'(1) << idx_q);
    seg_d     = ({1'b0, idx_q} < count_q) ? cur_seg : SEG_BLANK;
  end

  always_ff @(posedge clk) begin
    if (res) begin
      value_q   <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      err_q     <= 1'b0;
      seg_q     <= SEG_BLANK;
      dig_sel_q <= '1;
      div_q     <= '0;
      idx_q     <= '0;
    end else begin
      value_q   <= value_d;
      count_q   <= count_d;
      full_q    <= full_d;
      err_q     <= err_d;
      seg_q     <= seg_d;
      dig_sel_q <= dig_sel_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
    end
  end

  assign value   = value_q;
  assign count   = count_q;
  assign full    = full_q;
  assign err     = err_q;
  assign seg     = seg_q;
  assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_keypad_entry_display.sv
// Directed bench for keypad_entry_display with SCAN_DIV=4: entry, backspace,
// clear, reject pulses, scan order and reset behaviour.
module tb_keypad_entry_display;

  logic        clk;
  logic        res;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] value;
  logic [2:0]  count;
  logic        full;
  logic        err;
  logic [6:0]  seg;
  logic [3:0]  dig_sel;

  int errors;
  int checks;
  int t;

  keypad_entry_display #(.SCAN_DIV(4)) dut (
    .clk       (clk),
    .res       (res),
    .key_valid (key_valid),
    .key_code  (key_code),
    .value     (value),
    .count     (count),
    .full      (full),
    .err       (err),
    .seg       (seg),
    .dig_sel   (dig_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // t counts edges since reset was released; shown digit derives from it.
  task automatic tick();
    @(posedge clk);
    if (res) t = 0;
    else     t = t + 1;
    #1;
  endtask

  function automatic int shown();
    if (t < 1) return 0;
    return ((t - 1) / 4) % 4;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_digit(input int d);
    int n;
    n = 0;
    tick();
    while (shown() != d && n < 16) begin
      tick();
      n = n + 1;
    end
    if (n >= 16) begin
      errors = errors + 1;
      $display("FAIL wait_digit%0d observed=timeout expected=digit_shown", d);
    end
  endtask

  task automatic chk_digit(input string tag, input int d, input logic [6:0] exp_seg);
    logic [3:0] e;
    wait_digit(d);
    e = ~(4'b0001 << d);
    chk({tag, "_dig_sel"}, 16'(dig_sel), 16'(e));
    chk({tag, "_seg"}, 16'(seg), 16'(exp_seg));
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    t         = 0;
    res       = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;

    tick();
    tick();
    chk("rst_value", value, 16'h0000);
    chk("rst_count", 16'(count), 16'd0);
    chk("rst_full", 16'(full), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    chk("rst_seg", 16'(seg), 16'h007F);
    chk("rst_dig_sel", 16'(dig_sel), 16'h000F);

    res = 1'b0;
    for (int i = 0; i < 16; i++) begin
      logic [3:0] e;
      tick();
      e = ~(4'b0001 << (i / 4));
      chk("idle_dig_sel", 16'(dig_sel), 16'(e));
      chk("idle_seg", 16'(seg), 16'h007F);
    end
    chk("idle_value", value, 16'h0000);
    chk("idle_count", 16'(count), 16'd0);

    press(4'h1);
    press(4'h2);
    press(4'h3);
    chk("k123_value", value, 16'h0123);
    chk("k123_count", 16'(count), 16'd3);
    chk("k123_full", 16'(full), 16'd0);
    chk("k123_err", 16'(err), 16'd0);
    chk_digit("k123_d0", 0, 7'h30);
    chk_digit("k123_d1", 1, 7'h24);
    chk_digit("k123_d2", 2, 7'h79);
    chk_digit("k123_d3", 3, 7'h7F);

    press(4'hF);
    chk("clr1_value", value, 16'h0000);
    chk("clr1_count", 16'(count), 16'd0);
    chk("clr1_err", 16'(err), 16'd0);

    press(4'hA);
    press(4'hB);
    press(4'hC);
    press(4'hD);
    chk("abcd_value", value, 16'hABCD);
    chk("abcd_count", 16'(count), 16'd4);
    chk("abcd_full", 16'(full), 16'd1);
    chk("abcd_err", 16'(err), 16'd0);
    press(4'h5);
    chk("over_err", 16'(err), 16'd1);
    chk("over_value", value, 16'hABCD);
    chk("over_count", 16'(count), 16'd4);
    tick();
    chk("over_err_clear", 16'(err), 16'd0);
    chk_digit("abcd_d0", 0, 7'h21);
    chk_digit("abcd_d1", 1, 7'h46);
    chk_digit("abcd_d3", 3, 7'h08);

    press(4'hE);
    press(4'hE);
    chk("bksp_value", value, 16'h00AB);
    chk("bksp_count", 16'(count), 16'd2);
    chk("bksp_full", 16'(full), 16'd0);
    chk("bksp_err", 16'(err), 16'd0);
    chk_digit("bksp_d0", 0, 7'h03);
    chk_digit("bksp_d1", 1, 7'h08);
    chk_digit("bksp_d2", 2, 7'h7F);
    chk_digit("bksp_d3", 3, 7'h7F);

    press(4'hF);
    chk("clr2_value", value, 16'h0000);
    chk("clr2_count", 16'(count), 16'd0);
    chk("clr2_err", 16'(err), 16'd0);
    press(4'hF);
    chk("clr_empty_err", 16'(err), 16'd0);
    press(4'hE);
    chk("bksp_empty_err", 16'(err), 16'd1);
    chk("bksp_empty_count", 16'(count), 16'd0);
    tick();
    chk("bksp_empty_err_clear", 16'(err), 16'd0);

    key_valid = 1'b1;
    key_code  = 4'h7;
    tick();
    tick();
    tick();
    key_valid = 1'b0;
    chk("hold7_value", value, 16'h0777);
    chk("hold7_count", 16'(count), 16'd3);
    chk_digit("hold7_d2", 2, 7'h78);

    tick();
    tick();
    res       = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'h9;
    tick();
    chk("midrst_value", value, 16'h0000);
    chk("midrst_count", 16'(count), 16'd0);
    chk("midrst_full", 16'(full), 16'd0);
    chk("midrst_err", 16'(err), 16'd0);
    chk("midrst_seg", 16'(seg), 16'h007F);
    chk("midrst_dig_sel", 16'(dig_sel), 16'h000F);
    res       = 1'b0;
    key_valid = 1'b0;
    tick();
    chk("release_dig_sel", 16'(dig_sel), 16'h000E);
    chk("release_value", value, 16'h0000);
    chk("release_seg", 16'(seg), 16'h007F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_entry_display.md
# keypad_entry_display

Downstream consumer of the 4x4 keypad scanner. Takes one-cycle key-code strobes from the scanner and maintains a 4-digit hex entry buffer with backspace and clear. Time-multiplexes the buffer onto one shared active-low 7-segment bus with active-low digit enables. Sits between the keypad scanner and the board's 4-digit display, and replaces the scanner's single-digit out7 path.

## Interface
- SCAN_DIV, 4: clock cycles each digit is held on the bus; legal range 1..65535.
- clk  in  1  system clock; all state updates on the rising edge.
- res  in  1  reset, synchronous, active-high.
- key_valid  in  1  one-cycle strobe; key_code is valid in that cycle.
- key_code  in  4  scanner code: 0x0–0xD hex digit, 0xE backspace ('*'), 0xF clear ('#').
- value  out  16  entry buffer; digit 0 (newest) in [3:0]; unused digits read 0.
- count  out  3  number of entered digits, 0..4.
- full  out  1  high when count==4.
- err  out  1  one-cycle pulse on a rejected key.
- seg  out  7  active-low segments: bit0=a … bit6=g.
- dig_sel  out  4  active-low one-hot digit enable; bit0 = rightmost digit.

## Operation
- Key handling, on a cycle with key_valid=1:
  - Digit (0x0–0xD), count<4: value <= {value[11:0], key_code}; count+1.
  - Digit, count==4: buffer unchanged; err=1 for one cycle.
  - Backspace, count>0: value <= {4'h0, value[15:4]}; count−1.
  - Backspace, count==0: no change; err pulse.
  - Clear: value=0, count=0, no err, including when already empty.
- key_valid held high for k cycles counts as k separate keys. No edge detection here; the scanner guarantees one-cycle strobes.
- Scan engine:
  - div counts 0..SCAN_DIV−1.
  - At div==SCAN_DIV−1, div wraps to 0 and idx advances 0→1→2→3→0.
- Display of digit idx:
  - Displayed only if idx<count. Otherwise seg=7'h7F (blank) with dig_sel still driven, so brightness stays uniform.
  - Hex decode (active-low): 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, B→03, C→46, D→21.
- Reset values: value=0, count=0, full=0, err=0, seg=7'h7F, dig_sel=4'hF, div=0, idx=0.

## Timing
- Key strobe at edge N → value/count/full/err valid after edge N+1 (1-cycle latency). err clears after edge N+2 unless another rejected key arrives.
- seg/dig_sel are registered from the current idx and current value/count. A buffer change reaches seg one cycle after value changes, once that digit is scanned.
- First post-reset cycle: dig_sel=4'b1110. Each digit is held exactly SCAN_DIV cycles; one full frame is 4·SCAN_DIV cycles.
- Scanning runs continuously and is independent of key activity. Key events never reset div or idx.
- res=1 in the same cycle as key_valid=1: reset wins and the key is dropped.
- res asserted mid-frame: all state returns to reset values on that edge, and scanning restarts at digit 0.
- SCAN_DIV=1: idx advances every cycle. div is held at 0.

## Structure
- Shared package: key-code constants (KEY_BKSP=4'hE, KEY_CLR=4'hF), SEG_BLANK=7'h7F, and the 14-entry segment pattern table.
- One sub-module: hex_to_seg7, a combinational 4-bit to 7-bit active-low decoder. Its output is registered in the parent.
- Top holds: the entry buffer/counter, the div/idx scan counters, and the output registers. div width is 16 bits.

## Test plan
- Reset, then idle 16 cycles (SCAN_DIV=4) → seg=7F throughout; dig_sel cycles 1110,1101,1011,0111, each for 4 cycles; value=0000, count=0.
- Strobe keys 1,2,3 → value=0x0123, count=3; digit 0 shows 30, digit 1 shows 24, digit 2 shows 79, digit 3 blank 7F.
- Strobe keys A,B,C,D, then 5 → value=0xABCD, full=1; the fifth key gives an err pulse and value stays 0xABCD.
- Backspace twice on 0xABCD → 0x00AB, count=2, digits 2–3 blank. Clear → 0x0000, count=0, no err. Backspace on empty → err pulse.
- key_valid held 3 cycles with code 7 → value=0x0777, count=3.
- Assert res mid-frame together with key_valid (code 9) → key ignored; all outputs take reset values the next cycle; dig_sel=1110 the cycle after release.
